// File: rtl/me_pkg.sv
// Shared definitions for the motion-vector sequencer.
// - Width and offset helpers derived from the block and search-window geometry.
// - The sequencer state encoding.
// - The output record layout for the default geometry
//   (TB_LENGTH=16, SW_LENGTH=64, PE_OUT_WIDTH=8, NUM_BLOCKS=8).
package me_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of candidate positions along one axis of the search window.
  function automatic int range_f(input int sw_length, input int tb_length);
    return sw_length - tb_length + 1;
  endfunction

  // Distance from the window corner to the zero-motion candidate.
  function automatic int offset_f(input int sw_length, input int tb_length);
    return (sw_length - tb_length) / 2;
  endfunction

  function automatic int cnt_width_f(input int sw_length, input int tb_length);
    return clog2_f(range_f(sw_length, tb_length) * range_f(sw_length, tb_length));
  endfunction

  function automatic int sad_width_f(input int tb_length, input int pe_out_width);
    return clog2_f(tb_length * tb_length) + pe_out_width;
  endfunction

  // One extra bit so that +/-OFFSET fits in two's complement.
  function automatic int mv_width_f(input int sw_length, input int tb_length);
    return clog2_f(range_f(sw_length, tb_length)) + 1;
  endfunction

  function automatic int idx_width_f(input int num_blocks);
    return (num_blocks > 1) ? clog2_f(num_blocks) : 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CONV    = 3'd2,
    ST_PUSH    = 3'd3,
    ST_WAITLOW = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam int DEF_IDX_WIDTH = idx_width_f(8);
  localparam int DEF_MV_WIDTH  = mv_width_f(64, 16);
  localparam int DEF_SAD_WIDTH = sad_width_f(16, 8);

  typedef struct packed {
    logic [DEF_IDX_WIDTH-1:0]       idx;
    logic signed [DEF_MV_WIDTH-1:0] mv_x;
    logic signed [DEF_MV_WIDTH-1:0] mv_y;
    logic [DEF_SAD_WIDTH-1:0]       sad;
  } mv_rec_t;

endpackage

// File: rtl/mv_fifo.sv
// Small synchronous FIFO for motion-vector records.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   push/push_data write request and record
//   pop/pop_data   read request and head record (zero while empty)
//   full/empty     occupancy flags
// A push while full is accepted when a pop happens on the same edge.
module mv_fifo
  import me_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PTR_W = clog2_f(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Gating keeps the head at zero out of reset without resetting storage.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/me_mv_sequencer.sv
// Downstream controller for the full-search motion-estimation core.
// Requests one ME result per block, turns the winning raster index into a
// signed motion vector and queues {idx, mv_x, mv_y, sad} records.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, busy, done        run control/status (done pulses on last push)
//   me_req, me_ack           four-phase handshake with the ME core
//   me_min_cnt, me_min_sad   winning candidate index and its SAD
//   out_valid, out_ready     record stream handshake
//   out_idx, out_mv_x, out_mv_y, out_sad   head record fields
module me_mv_sequencer
  import me_pkg::*;
#(
  parameter int  TB_LENGTH    = 16,
  parameter int  SW_LENGTH    = 64,
  parameter int  PE_OUT_WIDTH = 8,
  parameter int  NUM_BLOCKS   = 8,
  parameter int  FIFO_DEPTH   = 4,
  localparam int RANGE        = range_f(SW_LENGTH, TB_LENGTH),
  localparam int OFFSET       = offset_f(SW_LENGTH, TB_LENGTH),
  localparam int CNT_WIDTH    = cnt_width_f(SW_LENGTH, TB_LENGTH),
  localparam int SAD_WIDTH    = sad_width_f(TB_LENGTH, PE_OUT_WIDTH),
  localparam int MV_WIDTH     = mv_width_f(SW_LENGTH, TB_LENGTH),
  localparam int IDX_WIDTH    = idx_width_f(NUM_BLOCKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [CNT_WIDTH-1:0] me_min_cnt,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [MV_WIDTH-1:0]  out_mv_x,
  output logic [MV_WIDTH-1:0]  out_mv_y,
  output logic [SAD_WIDTH-1:0] out_sad
);

  typedef struct packed {
    logic [IDX_WIDTH-1:0]       idx;
    logic signed [MV_WIDTH-1:0] mv_x;
    logic signed [MV_WIDTH-1:0] mv_y;
    logic [SAD_WIDTH-1:0]       sad;
  } rec_t;

  localparam int REC_WIDTH = $bits(rec_t);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] blk_q, blk_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [MV_WIDTH-1:0]  y_q, y_d;
  logic [SAD_WIDTH-1:0] sad_q, sad_d;
  logic                 fifo_push, fifo_full, fifo_empty, push_ok;
  rec_t                 push_rec, head_rec;
  logic [REC_WIDTH-1:0] head_bits;

  // A full FIFO still takes the record when the consumer pops the same edge.
  assign push_ok = !fifo_full || out_ready;

  // In PUSH the remainder is already below RANGE, so it fits MV_WIDTH bits.
  assign push_rec.idx  = blk_q;
  assign push_rec.mv_x = MV_WIDTH'(rem_q) - MV_WIDTH'(OFFSET);
  assign push_rec.mv_y = y_q - MV_WIDTH'(OFFSET);
  assign push_rec.sad  = sad_q;

  // Combinational from state so an asynchronous reset drops them at once.
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    rem_d     = rem_q;
    y_d       = y_q;
    sad_d     = sad_q;
    me_req    = 1'b0;
    done      = 1'b0;
    fifo_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          blk_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        me_req = 1'b1;
        if (me_ack) begin
          rem_d   = me_min_cnt;
          sad_d   = me_min_sad;
          y_d     = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // Row/column split by repeated subtraction; y saturates at RANGE-1
        // so an out-of-range index cannot wrap the vertical component.
        if ((rem_q >= CNT_WIDTH'(RANGE)) && (y_q < MV_WIDTH'(RANGE - 1))) begin
          rem_d = rem_q - CNT_WIDTH'(RANGE);
          y_d   = y_q + 1'b1;
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        if (push_ok) begin
          if (blk_q == IDX_WIDTH'(NUM_BLOCKS - 1)) begin
            done    = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            blk_d   = blk_q + 1'b1;
            state_d = ST_WAITLOW;
          end
        end
      end
      ST_WAITLOW: begin
        if (!me_ack) state_d = ST_REQ;
      end
      ST_DRAIN: begin
        if (!me_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    y_q   <= y_d;
    sad_q <= sad_d;
  end

  mv_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (out_ready),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rec  = rec_t'(head_bits);
  assign out_valid = !fifo_empty;
  assign out_idx   = head_rec.idx;
  assign out_mv_x  = head_rec.mv_x;
  assign out_mv_y  = head_rec.mv_y;
  assign out_sad   = head_rec.sad;

endmodule

// File: tb/tb_me_mv_sequencer.sv
`timescale 1ns/1ps
module tb_me_mv_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               me_ack = 1'b0;
  logic               out_ready = 1'b0;
  logic [11:0]        me_min_cnt = '0;
  logic [15:0]        me_min_sad = '0;
  logic               busy, done, me_req, out_valid;
  logic [2:0]         out_idx;
  logic signed [6:0]  out_mv_x, out_mv_y;
  logic [15:0]        out_sad;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    int cnt;
    int sad;
    int mvx;
    int mvy;
  } vec_t;

  typedef struct {
    int idx;
    int mvx;
    int mvy;
    int sad;
  } rec_t;

  vec_t vecs [8];
  rec_t got_q [$];

  always #5 clk = ~clk;

  me_mv_sequencer #(
    .TB_LENGTH    (16),
    .SW_LENGTH    (64),
    .PE_OUT_WIDTH (8),
    .NUM_BLOCKS   (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .me_req     (me_req),
    .me_ack     (me_ack),
    .me_min_cnt (me_min_cnt),
    .me_min_sad (me_min_sad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_mv_x   (out_mv_x),
    .out_mv_y   (out_mv_y),
    .out_sad    (out_sad)
  );

  // Record every accepted head entry and every done pulse, mid-cycle.
  always @(negedge clk) begin
    rec_t r;
    if (out_valid && out_ready) begin
      r.idx = int'(out_idx);
      r.mvx = int'(out_mv_x);
      r.mvy = int'(out_mv_y);
      r.sad = int'(out_sad);
      got_q.push_back(r);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Answer one ME request; keep ack high for 'hold' extra cycles.
  task automatic serve(input int cnt, input int sad, input int hold);
    int n;
    logic req_seen;
    n = 0;
    while (!me_req && n < 300) begin
      tick();
      n++;
    end
    chk("req_wait", me_req, 1'b1);
    me_ack     = 1'b1;
    me_min_cnt = 12'(cnt);
    me_min_sad = 16'(sad);
    tick();
    chk("req_drop_after_ack", me_req, 1'b0);
    req_seen = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (me_req) req_seen = 1'b1;
    end
    if (hold > 0) chk("req_low_while_ack_high", req_seen, 1'b0);
    me_ack = 1'b0;
  endtask

  task automatic wait_records(input int want);
    int n;
    n = 0;
    while ((busy || got_q.size() < want) && n < 500) begin
      tick();
      n++;
    end
    chk("run_finish_wait", (n < 500), 1'b1);
  endtask

  task automatic check_run(input string tag);
    chk({tag, " count"}, got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      chk($sformatf("%s rec%0d idx", tag, i), got_q[i].idx, i);
      chk($sformatf("%s rec%0d mv_x", tag, i), got_q[i].mvx, vecs[i].mvx);
      chk($sformatf("%s rec%0d mv_y", tag, i), got_q[i].mvy, vecs[i].mvy);
      chk($sformatf("%s rec%0d sad", tag, i), got_q[i].sad, vecs[i].sad);
    end
  endtask

  initial begin
    logic head_ok;
    int n;

    // {cnt, sad, mv_x, mv_y}; RANGE=49, OFFSET=24.
    vecs[0] = '{1200, 16'h0123,   0,   0};
    vecs[1] = '{   0, 16'h0001, -24, -24};
    vecs[2] = '{2400, 16'hFFFF,  24,  24};
    vecs[3] = '{  49, 16'h0200, -24, -23};
    vecs[4] = '{  48, 16'h0030,  24, -24};
    vecs[5] = '{ 100, 16'h1111, -22, -22};
    vecs[6] = '{1225, 16'h8000, -24,   1};
    vecs[7] = '{2352, 16'h00FF, -24,  24};

    // Reset state.
    repeat (3) tick();
    chk("reset busy", busy, 1'b0);
    chk("reset me_req", me_req, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle busy", busy, 1'b0);
    chk("idle done", done, 1'b0);
    chk("idle out_idx", out_idx, 0);
    chk("idle out_mv_x", out_mv_x, 0);
    chk("idle out_sad", out_sad, 0);

    // Run A: consumer always ready; ack held across PUSH on block 4,
    // stray start while busy, long ack hold on the last block.
    out_ready = 1'b1;
    pulse_start();
    chk("A busy after start", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) pulse_start();
      if (i == 4) begin
        serve(vecs[i].cnt, vecs[i].sad, 60);
        chk("A rec4 pushed during ack hold", got_q.size(), 5);
        tick();
        chk("A req one cycle after ack low", me_req, 1'b1);
      end else if (i == 7) begin
        serve(vecs[i].cnt, vecs[i].sad, 70);
        chk("A busy held in drain", busy, 1'b1);
        chk("A done pulses", done_cnt, 1);
        tick();
        chk("A busy after ack low", busy, 1'b0);
      end else begin
        serve(vecs[i].cnt, vecs[i].sad, 0);
      end
    end
    wait_records(8);
    check_run("A");
    chk("A done once", done_cnt, 1);

    // Run B: backpressure until the FIFO fills and the sequencer stalls.
    got_q.delete();
    done_cnt  = 0;
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) serve(vecs[i].cnt, vecs[i].sad, 0);
    head_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (me_req || !out_valid || out_idx != 3'd0 || out_sad != 16'h0123) head_ok = 1'b0;
    end
    chk("B stalled with stable head", head_ok, 1'b1);
    chk("B nothing consumed", got_q.size(), 0);
    // Single pop while full: the stalled record enters on the same edge.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("B req low after pop edge", me_req, 1'b0);
    chk("B head advanced", out_idx, 1);
    tick();
    chk("B req after simultaneous push", me_req, 1'b1);
    chk("B one consumed", got_q.size(), 1);
    serve(vecs[5].cnt, vecs[5].sad, 0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
    end
    chk("B stalled again (full)", me_req, 1'b0);
    chk("B still one consumed", got_q.size(), 1);
    out_ready = 1'b1;
    serve(vecs[6].cnt, vecs[6].sad, 0);
    serve(vecs[7].cnt, vecs[7].sad, 0);
    wait_records(8);
    check_run("B");
    chk("B done once", done_cnt, 1);

    // Run C: reset while block 3 is converting, then a fresh run.
    got_q.delete();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) serve(vecs[i].cnt, vecs[i].sad, 0);
    serve(2400, 16'h0777, 0);
    repeat (5) tick();
    chk("C busy before reset", busy, 1'b1);
    chk("C out_valid before reset", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("C reset me_req", me_req, 1'b0);
    chk("C reset out_valid", out_valid, 1'b0);
    chk("C reset busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    pulse_start();
    serve(49, 16'h0055, 0);
    n = 0;
    while (got_q.size() < 1 && n < 200) begin
      tick();
      n++;
    end
    chk("C restart count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      chk("C restart idx", got_q[0].idx, 0);
      chk("C restart mv_x", got_q[0].mvx, -24);
      chk("C restart mv_y", got_q[0].mvy, -23);
      chk("C restart sad", got_q[0].sad, 16'h0055);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
